// File: rtl/mem_port_arbiter_if.sv
// Bundle of every signal between mem_port_arbiter, the two pipeline stages
// and the unified memory.
//
// Handshake:
//   Requesters raise a level request (if_req_i, or one of dm_read_i /
//   dm_write_i) and hold it, with address and store data, until their ack
//   pulses for one cycle. In the cycle after the ack they drop or change
//   the request. Data outputs are meaningful only while the matching ack
//   is high. The memory sees one mem_enable_o pulse per command and answers
//   later with exactly one mem_ack_i pulse carrying mem_rdata_i.
//   A second command is never issued before the first has completed.
interface mem_port_arbiter_if;
  // instruction-fetch stage
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_ack_o;
  // MEM stage
  logic        dm_read_i;
  logic        dm_write_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic [31:0] dm_rdata_o;
  logic        dm_ack_o;
  // memory
  logic        mem_enable_o;
  logic        mem_write_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  // pipeline control and status
  logic        stall_o;
  logic        err_o;
  logic [31:0] stall_cnt_o;
  // sequencer state for observation: 0 idle, 1 issue, 2 wait
  logic [1:0]  dbg_state;

  // arbiter view
  modport slave (
    input  if_req_i, if_addr_i,
    input  dm_read_i, dm_write_i, dm_addr_i, dm_wdata_i,
    input  mem_rdata_i, mem_ack_i,
    output if_data_o, if_ack_o,
    output dm_rdata_o, dm_ack_o,
    output mem_enable_o, mem_write_o, mem_addr_o, mem_wdata_o,
    output stall_o, err_o, stall_cnt_o, dbg_state
  );

  // environment view: pipeline stages plus memory
  modport master (
    output if_req_i, if_addr_i,
    output dm_read_i, dm_write_i, dm_addr_i, dm_wdata_i,
    output mem_rdata_i, mem_ack_i,
    input  if_data_o, if_ack_o,
    input  dm_rdata_o, dm_ack_o,
    input  mem_enable_o, mem_write_o, mem_addr_o, mem_wdata_o,
    input  stall_o, err_o, stall_cnt_o, dbg_state
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Sequencer for the single-ported unified memory shared by the fetch stage
// and the MEM stage. Grants one requester at a time (alternating under
// contention), issues a one-cycle command, waits for the memory ack or a
// timeout, and stalls the pipeline while any request is unserved.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  owner_t           own_q, last_q;
  logic [31:0]      addr_q, wdata_q;
  logic             write_q;
  logic [CNT_W-1:0] tmo_cnt_q;
  logic             err_q;
  logic [31:0]      stall_cnt_q;

  logic        if_active, dm_active;
  logic        in_issue, in_wait;
  logic        grant, grant_dm;
  logic        tmo_hit, done;
  logic        if_ack, dm_ack, stall;
  logic [31:0] ack_data;

  assign if_active = bus.if_req_i;
  assign dm_active = bus.dm_read_i | bus.dm_write_i;
  assign in_issue  = (state_q == S_ISSUE);
  assign in_wait   = (state_q == S_WAIT);

  // A real ack wins over a timeout landing in the same cycle.
  assign tmo_hit  = in_wait & ~bus.mem_ack_i & (tmo_cnt_q == TMO_LAST);
  assign done     = in_wait & (bus.mem_ack_i | tmo_hit);
  assign ack_data = (in_wait & bus.mem_ack_i) ? bus.mem_rdata_i : 32'h0;

  assign if_ack = done & (own_q == OWN_IF);
  assign dm_ack = done & (own_q == OWN_DM);
  assign stall  = (if_active & ~if_ack) | (dm_active & ~dm_ack);

  assign bus.if_ack_o     = if_ack;
  assign bus.dm_ack_o     = dm_ack;
  assign bus.if_data_o    = if_ack ? ack_data : 32'h0;
  assign bus.dm_rdata_o   = dm_ack ? ack_data : 32'h0;
  assign bus.mem_enable_o = in_issue;
  assign bus.mem_write_o  = in_issue & write_q;
  assign bus.mem_addr_o   = in_issue ? addr_q : 32'h0;
  assign bus.mem_wdata_o  = in_issue ? wdata_q : 32'h0;
  assign bus.stall_o      = stall;
  assign bus.err_o        = err_q;
  assign bus.stall_cnt_o  = stall_cnt_q;
  assign bus.dbg_state    = state_q;

  // Next-state and grant decision; under contention serve the side not served last.
  always_comb begin
    state_d  = state_q;
    grant    = 1'b0;
    grant_dm = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (if_active | dm_active) begin
          grant    = 1'b1;
          grant_dm = dm_active & (~if_active | (last_q == OWN_IF));
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset abandons any access in flight without an ack.
  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Latch the winning command at grant; record the owner on every completion,
  // timeouts included, so a hung access does not hand the port straight back.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      own_q   <= OWN_IF;
      last_q  <= OWN_IF;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      write_q <= 1'b0;
    end else begin
      if (grant) begin
        own_q   <= grant_dm ? OWN_DM : OWN_IF;
        addr_q  <= grant_dm ? bus.dm_addr_i : bus.if_addr_i;
        wdata_q <= grant_dm ? bus.dm_wdata_i : 32'h0;
        write_q <= grant_dm & bus.dm_write_i;
      end
      if (done) last_q <= own_q;
    end
  end

  // Timeout counter: cleared in the issue cycle, counts cycles spent waiting.
  always_ff @(posedge clk_i) begin
    if (!rst_i)       tmo_cnt_q <= '0;
    else if (in_issue) tmo_cnt_q <= '0;
    else if (in_wait)  tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i)       err_q <= 1'b0;
    else if (tmo_hit) err_q <= 1'b1;
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk_i) begin
    if (!rst_i)                             stall_cnt_q <= 32'h0;
    else if (stall && (stall_cnt_q != '1))  stall_cnt_q <= stall_cnt_q + 32'd1;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: reset, fetch, store, load,
// contention fairness, timeout, reset during an access, counter saturation.
module tb_mem_port_arbiter;
  localparam int unsigned TMO = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.TIMEOUT(TMO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // clock
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard entries: {owner is DM, expected data}
  logic [32:0] exp_q[$];

  // memory model controls
  int          mem_lat = 1;
  bit          mem_rand = 0;
  bit          mem_silent = 0;
  bit          mem_force_ack = 0;
  bit          mem_pulse = 0;
  bit          mem_override = 0;
  logic [31:0] mem_override_data = 32'h0;
  int          mem_cd = 0;
  logic [31:0] mem_pend_data = 32'h0;

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // memory model: answers each enable after a latency, drives at posedge+1
  initial begin
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_ack_i   = 1'b0;
      bus.mem_rdata_i = 32'h0;
      if (!rst) mem_cd = 0;
      if (mem_force_ack) begin
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = 32'hFFFF_FFFF;
      end else if (mem_pulse) begin
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = 32'h1357_9BDF;
        mem_pulse       = 0;
      end else if (mem_cd > 0) begin
        mem_cd--;
        if (mem_cd == 0) begin
          bus.mem_ack_i   = 1'b1;
          bus.mem_rdata_i = mem_pend_data;
        end
      end
      if (bus.mem_enable_o && rst && !mem_silent) begin
        mem_cd = mem_rand ? int'($urandom_range(4, 1)) : mem_lat;
        mem_pend_data = bus.mem_write_o ? 32'h0 :
                        (mem_override ? mem_override_data : model_rd(bus.mem_addr_o));
      end
    end
  end

  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b0;
    mem_force_ack = 1;
    tick();
    tick();
    @(negedge clk);
    n_checks++;
    if ({bus.dbg_state, bus.mem_enable_o, bus.mem_write_o, bus.if_ack_o, bus.dm_ack_o,
         bus.stall_o, bus.err_o} !== 8'h0) begin
      n_errors++;
      $display("FAIL reset_ctrl: got state=%0d en=%b wr=%b ifack=%b dmack=%b stall=%b err=%b, required all 0",
               bus.dbg_state, bus.mem_enable_o, bus.mem_write_o, bus.if_ack_o, bus.dm_ack_o,
               bus.stall_o, bus.err_o);
    end
    v = bus.mem_addr_o | bus.mem_wdata_o | bus.if_data_o | bus.dm_rdata_o | bus.stall_cnt_o;
    n_checks++;
    if (v !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_buses: got OR of addr/wdata/data/cnt=%h, required 0", v);
    end
    mem_force_ack = 0;
    mem_pulse = 1;
    tick();
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.if_ack_o, bus.dm_ack_o, bus.mem_enable_o} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_late_ack: got ifack=%b dmack=%b en=%b, required 0",
               bus.if_ack_o, bus.dm_ack_o, bus.mem_enable_o);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if ({bus.dbg_state, bus.if_ack_o, bus.dm_ack_o, bus.mem_enable_o} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_idle: got state=%0d ifack=%b dmack=%b en=%b, required idle/0",
               bus.dbg_state, bus.if_ack_o, bus.dm_ack_o, bus.mem_enable_o);
    end
  endtask

  task automatic test_fetch();
    logic [32:0] e;
    bit got;
    int n_en, n_st, ack_cyc;
    mem_rand = 0; mem_lat = 3; mem_silent = 0;
    mem_override = 1; mem_override_data = 32'h8C01_0004;
    tick();
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h40;
    exp_q.push_back({1'b0, 32'h8C01_0004});
    got = 0; n_en = 0; n_st = 0; ack_cyc = -1;
    for (int cyc = 0; cyc < 20 && !got; cyc++) begin
      @(negedge clk);
      if (bus.stall_o) n_st++;
      if (bus.mem_enable_o) begin
        n_en++;
        n_checks++;
        if ({bus.mem_write_o, bus.mem_addr_o} !== {1'b0, 32'h40}) begin
          n_errors++;
          $display("FAIL fetch_cmd: got wr=%b addr=%h, required wr=0 addr=00000040",
                   bus.mem_write_o, bus.mem_addr_o);
        end
      end
      if (bus.if_ack_o) begin
        got = 1; ack_cyc = cyc;
        e = exp_q.pop_front();
        n_checks++;
        if ({bus.dm_ack_o, bus.if_data_o} !== e) begin
          n_errors++;
          $display("FAIL fetch_data: got dmack=%b data=%h, required %h", bus.dm_ack_o, bus.if_data_o, e);
        end
      end
      tick();
    end
    bus.if_req_i = 1'b0;
    mem_override = 0;
    n_checks++;
    if (ack_cyc !== 4) begin
      n_errors++;
      $display("FAIL fetch_latency: got ack cycle %0d, required 4", ack_cyc);
    end
    n_checks++;
    if (n_en !== 1 || n_st !== 4) begin
      n_errors++;
      $display("FAIL fetch_pulses: got enables=%0d stall cycles=%0d, required 1 and 4", n_en, n_st);
    end
    @(negedge clk);
    n_checks++;
    if (bus.stall_cnt_o !== 32'd4 || bus.stall_o !== 1'b0) begin
      n_errors++;
      $display("FAIL fetch_stall_cnt: got cnt=%0d stall=%b, required 4 and 0", bus.stall_cnt_o, bus.stall_o);
    end
  endtask

  // dm access: write or read, checks command at issue, data and latency at ack
  task automatic run_dm(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int lat, input string name);
    logic [32:0] e;
    bit got;
    int ack_cyc;
    mem_rand = 0; mem_lat = lat; mem_silent = 0; mem_override = 0;
    tick();
    bus.dm_write_i = wr; bus.dm_read_i = ~wr;
    bus.dm_addr_i = addr; bus.dm_wdata_i = wdata;
    exp_q.push_back({1'b1, wr ? 32'h0 : model_rd(addr)});
    got = 0; ack_cyc = -1;
    for (int cyc = 0; cyc < 20 && !got; cyc++) begin
      @(negedge clk);
      if (bus.mem_enable_o) begin
        n_checks++;
        if ({bus.mem_write_o, bus.mem_addr_o} !== {wr, addr} ||
            (wr && bus.mem_wdata_o !== wdata)) begin
          n_errors++;
          $display("FAIL %s_cmd: got wr=%b addr=%h wdata=%h, required wr=%b addr=%h wdata=%h",
                   name, bus.mem_write_o, bus.mem_addr_o, bus.mem_wdata_o, wr, addr, wdata);
        end
      end
      if (bus.dm_ack_o) begin
        got = 1; ack_cyc = cyc;
        e = exp_q.pop_front();
        n_checks++;
        if ({~bus.if_ack_o, bus.dm_rdata_o} !== e) begin
          n_errors++;
          $display("FAIL %s_data: got ifack=%b data=%h, required %h", name, bus.if_ack_o, bus.dm_rdata_o, e);
        end
      end
      tick();
    end
    bus.dm_write_i = 1'b0; bus.dm_read_i = 1'b0;
    n_checks++;
    if (ack_cyc !== lat + 1) begin
      n_errors++;
      $display("FAIL %s_latency: got ack cycle %0d, required %0d", name, ack_cyc, lat + 1);
    end
  endtask

  task automatic test_store();
    run_dm(1'b1, 32'h100, 32'hDEAD_BEEF, 1, "store");
  endtask

  task automatic test_load();
    run_dm(1'b0, 32'h200, 32'h0, 2, "load");
  endtask

  task automatic test_contention();
    logic [32:0] e;
    int k_if, k_dm, n_ack;
    bit outstanding, upd_if, upd_dm;
    exp_q.delete();
    mem_rand = 1; mem_silent = 0; mem_override = 0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    k_if = 0; k_dm = 0;
    bus.if_req_i = 1'b1;  bus.if_addr_i = 32'h1000;
    bus.dm_read_i = 1'b1; bus.dm_addr_i = 32'h2000;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) exp_q.push_back({1'b1, model_rd(32'h2000 + 32'(4 * (i / 2)))});
      else            exp_q.push_back({1'b0, model_rd(32'h1000 + 32'(4 * (i / 2)))});
    end
    n_ack = 0; outstanding = 0;
    for (int cyc = 0; cyc < 200 && n_ack < 8; cyc++) begin
      @(negedge clk);
      upd_if = 0; upd_dm = 0;
      n_checks++;
      if (bus.stall_o !== 1'b1) begin
        n_errors++;
        $display("FAIL contend_stall: got %b at cycle %0d, required 1", bus.stall_o, cyc);
      end
      if (bus.mem_enable_o) begin
        n_checks++;
        if (outstanding) begin
          n_errors++;
          $display("FAIL contend_overlap: got enable while busy at cycle %0d, required none", cyc);
        end
        outstanding = 1;
      end
      if (bus.if_ack_o || bus.dm_ack_o) begin
        outstanding = 0;
        e = exp_q.pop_front();
        n_checks++;
        if ((bus.if_ack_o && bus.dm_ack_o) ||
            {bus.dm_ack_o, bus.dm_ack_o ? bus.dm_rdata_o : bus.if_data_o} !== e) begin
          n_errors++;
          $display("FAIL contend_grant %0d: got ifack=%b dmack=%b data=%h, required %h",
                   n_ack, bus.if_ack_o, bus.dm_ack_o,
                   bus.dm_ack_o ? bus.dm_rdata_o : bus.if_data_o, e);
        end
        upd_if = bus.if_ack_o; upd_dm = bus.dm_ack_o;
        n_ack++;
      end
      tick();
      if (upd_if) begin k_if++; bus.if_addr_i = 32'h1000 + 32'(4 * k_if); end
      if (upd_dm) begin k_dm++; bus.dm_addr_i = 32'h2000 + 32'(4 * k_dm); end
    end
    bus.if_req_i = 1'b0; bus.dm_read_i = 1'b0;
    mem_rand = 0;
    n_checks++;
    if (n_ack !== 8) begin
      n_errors++;
      $display("FAIL contend_count: got %0d acks, required 8", n_ack);
    end
  endtask

  task automatic test_timeout();
    logic [32:0] e;
    bit got;
    int ack_cyc;
    exp_q.delete();
    mem_silent = 1;
    tick();
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h300;
    exp_q.push_back({1'b0, 32'h0});
    got = 0; ack_cyc = -1;
    for (int cyc = 0; cyc < 40 && !got; cyc++) begin
      @(negedge clk);
      if (cyc == 5) begin
        n_checks++;
        if ({bus.mem_enable_o, bus.mem_write_o, bus.mem_addr_o, bus.mem_wdata_o} !== 66'h0) begin
          n_errors++;
          $display("FAIL timeout_wait_bus: got en=%b addr=%h, required 0", bus.mem_enable_o, bus.mem_addr_o);
        end
      end
      if (bus.if_ack_o) begin
        got = 1; ack_cyc = cyc;
        e = exp_q.pop_front();
        n_checks++;
        if ({bus.dm_ack_o, bus.if_data_o} !== e) begin
          n_errors++;
          $display("FAIL timeout_data: got dmack=%b data=%h, required %h", bus.dm_ack_o, bus.if_data_o, e);
        end
      end
      tick();
    end
    bus.if_req_i = 1'b0;
    mem_silent = 0;
    n_checks++;
    if (ack_cyc !== int'(TMO) + 1) begin
      n_errors++;
      $display("FAIL timeout_latency: got ack cycle %0d, required %0d", ack_cyc, TMO + 1);
    end
    @(negedge clk);
    n_checks++;
    if (bus.err_o !== 1'b1) begin
      n_errors++;
      $display("FAIL timeout_err: got %b, required 1", bus.err_o);
    end
    run_dm(1'b0, 32'h404, 32'h0, 2, "after_timeout");
    @(negedge clk);
    n_checks++;
    if (bus.err_o !== 1'b1) begin
      n_errors++;
      $display("FAIL timeout_err_sticky: got %b, required 1", bus.err_o);
    end
  endtask

  task automatic test_reset_mid_wait();
    mem_silent = 1;
    tick();
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h500;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      n_checks++;
      if (bus.if_ack_o !== 1'b0) begin
        n_errors++;
        $display("FAIL midwait_early_ack: got %b at cycle %0d, required 0", bus.if_ack_o, cyc);
      end
      tick();
    end
    rst = 1'b0;
    bus.if_req_i = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.dbg_state, bus.err_o, bus.if_ack_o, bus.mem_enable_o} !== 5'b0 ||
        bus.stall_cnt_o !== 32'h0) begin
      n_errors++;
      $display("FAIL midwait_reset: got state=%0d err=%b ack=%b en=%b cnt=%0d, required all 0",
               bus.dbg_state, bus.err_o, bus.if_ack_o, bus.mem_enable_o, bus.stall_cnt_o);
    end
    mem_silent = 0;
    mem_pulse = 1;
    tick();
    @(negedge clk);
    n_checks++;
    if ({bus.if_ack_o, bus.dm_ack_o, bus.dbg_state} !== 4'b0) begin
      n_errors++;
      $display("FAIL midwait_late_ack: got ifack=%b dmack=%b state=%0d, required 0",
               bus.if_ack_o, bus.dm_ack_o, bus.dbg_state);
    end
  endtask

  task automatic test_saturation();
    logic [32:0] e;
    bit got;
    int n_st;
    exp_q.delete();
    @(negedge clk);
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    #1;
    n_checks++;
    if (bus.stall_cnt_o !== 32'hFFFF_FFFE) begin
      n_errors++;
      $display("FAIL sat_preload: got %h, required fffffffe", bus.stall_cnt_o);
    end
    mem_rand = 0; mem_lat = 2; mem_silent = 0; mem_override = 0;
    tick();
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h600;
    exp_q.push_back({1'b0, model_rd(32'h600)});
    got = 0; n_st = 0;
    for (int cyc = 0; cyc < 20 && !got; cyc++) begin
      @(negedge clk);
      if (bus.stall_o) n_st++;
      if (bus.if_ack_o) begin
        got = 1;
        e = exp_q.pop_front();
        n_checks++;
        if ({bus.dm_ack_o, bus.if_data_o} !== e) begin
          n_errors++;
          $display("FAIL sat_data: got %h, required %h", bus.if_data_o, e);
        end
      end
      tick();
    end
    bus.if_req_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (n_st !== 3 || bus.stall_cnt_o !== 32'hFFFF_FFFF) begin
      n_errors++;
      $display("FAIL sat_hold: got stalls=%0d cnt=%h, required 3 and ffffffff", n_st, bus.stall_cnt_o);
    end
  endtask

  // sequence of scenarios and final report
  initial begin
    bus.if_req_i = 1'b0;   bus.if_addr_i = 32'h0;
    bus.dm_read_i = 1'b0;  bus.dm_write_i = 1'b0;
    bus.dm_addr_i = 32'h0; bus.dm_wdata_i = 32'h0;
    test_reset();
    test_fetch();
    test_store();
    test_load();
    test_contention();
    test_timeout();
    test_reset_mid_wait();
    test_saturation();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // hard bound on simulation time
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog");
  end

endmodule
